// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg
//   Shared definitions for the SPI-fronted burst memory (spi_mem_burst).
//   - state_t    : frame-control FSM encoding
//   - cmd_width  : command frame length (address bits + R/W bit)
//   - cnt_width  : width of the frame bit counter, sized to count a full
//                  command or a full data word, whichever is longer
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CMD       = 3'd1,
    RD_LOAD   = 3'd2,
    RD_SHIFT  = 3'd3,
    WR_SHIFT  = 3'd4,
    WR_COMMIT = 3'd5
  } state_t;

  function automatic int cmd_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int cnt_width(input int cmd_w, input int data_w);
    int longest;
    longest = (cmd_w > data_w) ? cmd_w : data_w;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync
//   Brings one asynchronous SPI pin into the clk domain through a 2-flop
//   synchroniser and derives single-cycle edge pulses from the synchronised
//   level. A pin edge shows up on rise/fall in the third clk cycle after it.
// Parameters
//   RST_VAL  level the synchroniser holds in reset (idle level of the pin)
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   pin    in   raw asynchronous pin
//   level  out  synchronised pin level
//   rise   out  1-clk pulse on a synchronised 0->1 transition
//   fall   out  1-clk pulse on a synchronised 1->0 transition
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
      prev_p2 <= RST_VAL;
    end else begin
      meta_p0 <= pin;
      // stage 1: metastability settled
      sync_p1 <= meta_p0;
      // stage 2: previous synchronised level for edge detection
      prev_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~prev_p2;
  assign fall  = ~sync_p1 & prev_p2;

endmodule

// File: rtl/spi_mem_burst.sv
// spi_mem_burst
//   SPI mode-0 slave (MSB first) in front of an on-chip RAM. A frame is a
//   command (ADDR_W address bits, then R/W bit, 1 = read) followed by any
//   number of DATA_W-bit words until CS rises. The address auto-increments
//   per word and wraps from DEPTH-1 to 0. Addresses >= DEPTH drop writes and
//   read as zero. CS rising part-way through a command or word pulses
//   frame_err and discards the partial word.
// Parameters
//   ADDR_W  address bits in the command
//   DATA_W  bits per data word
//   DEPTH   implemented words (1 .. 2**ADDR_W)
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   sclk_pin      in   SPI clock (asynchronous)
//   cs_pin        in   SPI chip select, active low (asynchronous)
//   mosi_pin      in   SPI master-out data (asynchronous)
//   fault_inject  in   only with SPI_MEM_FAULT_EN: forces bit 0 of a
//                      committed word to 0 while high
//   miso_pin      out  SPI slave-out data (registered)
//   miso_oe       out  drive enable for miso_pin
//   busy          out  synchronised CS-low indication
//   frame_err     out  1-clk pulse on a CS rise mid-command or mid-word
//   leds          out  low 8 bits of the last committed write word
// Configuration
//   SPI_MEM_FAULT_EN  adds fault_inject (stuck-at-0 emulation on bit 0)
module spi_mem_burst
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
`ifdef SPI_MEM_FAULT_EN
  input  logic       fault_inject,
`endif
  output logic       miso_pin,
  output logic       miso_oe,
  output logic       busy,
  output logic       frame_err,
  output logic [7:0] leds
);

  localparam int CMD_W = cmd_width(ADDR_W);
  localparam int CNT_W = cnt_width(CMD_W, DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w,
                                                   input logic b);
    logic [DATA_W:0] t;
    t = {w, b};
    return t[DATA_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] shift_addr(input logic [ADDR_W-1:0] a,
                                                   input logic b);
    logic [ADDR_W:0] t;
    t = {a, b};
    return t[ADDR_W-1:0];
  endfunction

  function automatic logic [7:0] low_byte(input logic [DATA_W-1:0] w);
    logic [DATA_W+7:0] t;
    t = {8'h00, w};
    return t[7:0];
  endfunction

  logic sclk_lvl, sclk_pos, sclk_neg;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_pin_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .pin(sclk_pin),
    .level(sclk_lvl), .rise(sclk_pos), .fall(sclk_neg)
  );

  // CS idles high, so its synchroniser resets to 1 to keep busy low.
  spi_pin_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .pin(cs_pin),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .pin(mosi_pin),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_edges = ^{sclk_lvl, cs_rise, cs_fall, mosi_rise, mosi_fall};

  state_t              state, state_n;
  logic                frame_err_n;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   addr_inc;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic                fetch_pend;
  logic                load_pend;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   rd_data;
  logic [DATA_W-1:0]   wr_word;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign busy     = ~cs_lvl;
  assign in_range = ({1'b0, addr} < DEPTH_V);
  assign idx      = addr[IDX_W-1:0];
  assign addr_inc = (addr == ADDR_LAST) ? '0 : addr + ADDR_W'(1);

`ifdef SPI_MEM_FAULT_EN
  assign wr_word = {shreg[DATA_W-1:1] , shreg[0] & ~fault_inject};
`else
  assign wr_word = shreg;
`endif

  always_comb begin
    state_n     = state;
    frame_err_n = 1'b0;
    if (state != IDLE && cs_lvl) begin
      state_n     = IDLE;
      frame_err_n = (bit_cnt != '0);
    end else begin
      case (state)
        IDLE:      if (!cs_lvl) state_n = CMD;
        CMD:       if (sclk_pos && bit_cnt == CMD_LAST)
                     state_n = mosi_lvl ? RD_LOAD : WR_SHIFT;
        RD_LOAD:   state_n = RD_SHIFT;
        RD_SHIFT:  state_n = RD_SHIFT;
        WR_SHIFT:  if (sclk_pos && bit_cnt == WORD_LAST) state_n = WR_COMMIT;
        WR_COMMIT: state_n = WR_SHIFT;
        default:   state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_err  <= 1'b0;
      miso_oe    <= 1'b0;
      miso_pin   <= 1'b0;
      leds       <= 8'h00;
      bit_cnt    <= '0;
      addr       <= '0;
      fetch_pend <= 1'b0;
      load_pend  <= 1'b0;
    end else begin
      state      <= state_n;
      frame_err  <= frame_err_n;
      miso_oe    <= (state_n == RD_LOAD) || (state_n == RD_SHIFT);
      fetch_pend <= 1'b0;
      // Next read word: the address moves first, the RAM answers one clk
      // later, and the shifter takes it the clk after that.
      load_pend  <= fetch_pend || (state == RD_LOAD);
      case (state)
        CMD: begin
          if (sclk_pos) begin
            if (bit_cnt == CMD_LAST) begin
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              addr    <= shift_addr(addr, mosi_lvl);
            end
          end
        end
        RD_SHIFT: begin
          if (sclk_neg) miso_pin <= shreg[DATA_W-1];
          if (sclk_pos) begin
            if (bit_cnt == WORD_LAST) begin
              bit_cnt    <= '0;
              addr       <= addr_inc;
              fetch_pend <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        WR_SHIFT: begin
          if (sclk_pos) begin
            if (bit_cnt == WORD_LAST) bit_cnt <= '0;
            else                      bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        WR_COMMIT: begin
          addr <= addr_inc;
          if (in_range) leds <= low_byte(wr_word);
        end
        default: ;
      endcase
      if (state_n == IDLE) begin
        bit_cnt  <= '0;
        miso_pin <= 1'b0;
      end
    end
  end

  // RAM, read register and shifter carry data only and are not reset.
  always_ff @(posedge clk) begin
    rd_data <= in_range ? mem[idx] : '0;
    if (state == WR_COMMIT && in_range) mem[idx] <= wr_word;
    case (state)
      WR_SHIFT: if (sclk_pos) shreg <= shift_word(shreg, mosi_lvl);
      RD_SHIFT: begin
        if (load_pend)     shreg <= rd_data;
        else if (sclk_neg) shreg <= shreg << 1;
      end
      default: ;
    endcase
  end

endmodule
